// File: rtl/div3_rr_scheduler.sv
// Round-robin front end sharing one bit-serial divide-by-3 engine between
// NUM_REQ requesters; quotient, remainder and owner id leave on one response channel.
module div3_rr_scheduler #(
    parameter int SIZE    = 20,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    sys_clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*SIZE-1:0] req_divident,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [SIZE-1:0]         rsp_quotient,
    output logic [1:0]              rsp_reminder,
    output logic                    busy
);

    localparam int CNT_W = $clog2(SIZE);

    // Handshakes: a transfer happens on a posedge where valid and ready are both
    // high. req_ready is only ever raised in IDLE and never depends on the
    // requester's data; rsp_valid, once high, holds with stable payload until
    // rsp_ready is seen, and rsp_ready is ignored while rsp_valid is low.
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    pend_id;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic [SIZE-1:0]    operand;
    logic [SIZE-1:0]    quot;
    logic [SIZE-1:0]    quot_next;
    logic [1:0]         rem;
    logic [1:0]         rem_next;
    logic [2:0]         t;
    logic               q_bit;
    logic [CNT_W-1:0]   cnt;

    // Search starts just above the last winner, so it becomes lowest priority.
    always_comb begin
        int idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any   = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    // One restoring step: t = 2r + b is at most 5, so a single subtract of 3 suffices.
    assign t         = {rem, 1'b0} + {2'b00, operand[SIZE-1]};
    assign q_bit     = (t >= 3'd3);
    assign rem_next  = q_bit ? 2'(t - 3'd3) : t[1:0];
    assign quot_next = {quot[SIZE-2:0], q_bit};

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= ID_W'(NUM_REQ - 1);
            pend_id      <= '0;
            operand      <= '0;
            quot         <= '0;
            rem          <= '0;
            cnt          <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_quotient <= '0;
            rsp_reminder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        operand <= req_divident[int'(grant_id)*SIZE +: SIZE];
                        pend_id <= grant_id;
                        rr_ptr  <= grant_id;
                        quot    <= '0;
                        rem     <= '0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    operand <= {operand[SIZE-2:0], 1'b0};
                    quot    <= quot_next;
                    rem     <= rem_next;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(SIZE - 1)) begin
                        state        <= DONE;
                        rsp_valid    <= 1'b1;
                        rsp_quotient <= quot_next;
                        rsp_reminder <= rem_next;
                        rsp_id       <= pend_id;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div3_rr_scheduler.sv
// Bench for div3_rr_scheduler: directed scenarios with literal results plus a
// random phase, all compared every cycle against a behavioural model.
module tb_div3_rr_scheduler;

    localparam int SIZE    = 20;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int EXP_W   = ID_W + SIZE + 2;

    logic                    sys_clock = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*SIZE-1:0] req_divident = '0;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b0;
    logic [ID_W-1:0]         rsp_id;
    logic [SIZE-1:0]         rsp_quotient;
    logic [1:0]              rsp_reminder;
    logic                    busy;

    div3_rr_scheduler #(.SIZE(SIZE), .NUM_REQ(NUM_REQ)) dut (
        .sys_clock    (sys_clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_divident (req_divident),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_quotient (rsp_quotient),
        .rsp_reminder (rsp_reminder),
        .busy         (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clock = ~sys_clock;

    int cyc = 0;
    always @(posedge sys_clock) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    logic [EXP_W-1:0] exp_q[$];
    int log_id[$];
    int log_q[$];
    int log_r[$];
    int dut_grant_id[$];
    int dut_grant_cyc[$];
    logic [NUM_REQ-1:0] ready_seen = '0;
    logic [NUM_REQ-1:0] acc_seen = '0;
    bit keep_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              chk_en = 1'b0;
    bit              m_has_job = 1'b0;
    int              m_age = 0;
    int              m_ptr = NUM_REQ - 1;
    int              m_id = 0;
    logic [SIZE-1:0] m_div = '0;
    int              m_last_id = 0;
    int              m_last_q = 0;
    int              m_last_r = 0;

    function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Compare on the falling edge, then advance the model to the next rising edge.
    always @(negedge sys_clock) begin
        logic [NUM_REQ-1:0] exp_ready;
        logic [EXP_W-1:0]   exp_e;
        int                 w;
        if (chk_en) begin
            exp_ready = '0;
            if (!m_has_job) begin
                w = rr_pick(m_ptr, req_valid);
                if (w >= 0) exp_ready[w] = 1'b1;
            end
            check("req_ready", req_ready, exp_ready);
            check("busy", busy, m_has_job);
            check("rsp_valid", rsp_valid, m_has_job && m_age == SIZE);
            check("rsp_id", rsp_id, m_last_id);
            check("rsp_quotient", rsp_quotient, m_last_q);
            check("rsp_reminder", rsp_reminder, m_last_r);
            ready_seen = ready_seen | req_ready;
            if (!reset && rsp_valid && rsp_ready) begin
                log_id.push_back(int'(rsp_id));
                log_q.push_back(int'(rsp_quotient));
                log_r.push_back(int'(rsp_reminder));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d q %0d with nothing expected", rsp_id, rsp_quotient);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("rsp_scoreboard", {rsp_id, rsp_quotient, rsp_reminder}, exp_e);
                end
            end
        end
        acc_seen = reset ? '0 : (req_valid & req_ready);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_seen[i]) begin
                dut_grant_id.push_back(i);
                dut_grant_cyc.push_back(cyc);
            end
        end
        if (reset) begin
            m_has_job = 1'b0;
            m_ptr     = NUM_REQ - 1;
            m_last_id = 0;
            m_last_q  = 0;
            m_last_r  = 0;
            exp_q.delete();
            chk_en    = 1'b1;
        end else if (!m_has_job) begin
            w = rr_pick(m_ptr, req_valid);
            if (w >= 0) begin
                m_has_job = 1'b1;
                m_age     = 0;
                m_ptr     = w;
                m_id      = w;
                m_div     = req_divident[w*SIZE +: SIZE];
                exp_q.push_back({ID_W'(w), SIZE'(m_div / 3), 2'(m_div % 3)});
            end
        end else if (m_age < SIZE) begin
            m_age++;
            if (m_age == SIZE) begin
                m_last_id = m_id;
                m_last_q  = int'(m_div / 3);
                m_last_r  = int'(m_div % 3);
            end
        end else if (rsp_ready) begin
            m_has_job = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge sys_clock);
        #1;
        if (!keep_valid) req_valid = req_valid & ~acc_seen;
    endtask

    task automatic do_reset(input int n);
        reset        = 1'b1;
        req_valid    = '0;
        rsp_ready    = 1'b0;
        req_divident = '0;
        keep_valid   = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [SIZE-1:0] d);
        req_divident[i*SIZE +: SIZE] = d;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_rsps(input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("rsp_wait_budget", log_q.size() >= n, 1);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        while (dut_grant_id.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("grant_wait_budget", dut_grant_id.size() >= n, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        int g0;
        int lat;
        int bq[4];
        int br[4];
        logic [SIZE-1:0] bops[4];
        logic [SIZE-1:0] d;

        do_reset(3);

        // Single request, latency and result from requester 0
        n0 = log_q.size();
        rsp_ready = 1'b1;
        set_req(0, SIZE'(100));
        @(negedge sys_clock);
        check("t1_ready_onehot", req_ready, 4'b0001);
        tick();
        @(negedge sys_clock);
        check("t1_busy_after_accept", busy, 1);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            tick();
            lat++;
            @(negedge sys_clock);
        end
        check("t1_latency", lat, 20);
        wait_rsps(n0 + 1, 10);
        if (log_q.size() > n0) begin
            check("t1_q", log_q[n0], 33);
            check("t1_r", log_r[n0], 1);
            check("t1_id", log_id[n0], 0);
        end

        // Boundary dividends on requester 3
        bops = '{20'hFFFFF, 20'd0, 20'd2, 20'd4};
        bq   = '{349525, 0, 0, 1};
        br   = '{0, 0, 2, 1};
        for (int i = 0; i < 4; i++) begin
            n0 = log_q.size();
            set_req(3, bops[i]);
            wait_rsps(n0 + 1, 60);
            if (log_q.size() > n0) begin
                check("t2_q", log_q[n0], bq[i]);
                check("t2_r", log_r[n0], br[i]);
                check("t2_id", log_id[n0], 3);
            end
        end

        // All four valid at once: order 0,1,2,3, 22 edges apart
        do_reset(2);
        rsp_ready = 1'b1;
        n0 = log_q.size();
        g0 = dut_grant_id.size();
        set_req(0, SIZE'(7));
        set_req(1, SIZE'(8));
        set_req(2, SIZE'(9));
        set_req(3, SIZE'(10));
        wait_rsps(n0 + 4, 150);
        if (log_q.size() >= n0 + 4 && dut_grant_id.size() >= g0 + 4) begin
            bq = '{2, 2, 3, 3};
            br = '{1, 2, 0, 1};
            for (int i = 0; i < 4; i++) begin
                check("t3_grant_order", dut_grant_id[g0 + i], i);
                check("t3_id", log_id[n0 + i], i);
                check("t3_q", log_q[n0 + i], bq[i]);
                check("t3_r", log_r[n0 + i], br[i]);
                if (i > 0) check("t3_spacing", dut_grant_cyc[g0 + i] - dut_grant_cyc[g0 + i - 1], 22);
            end
        end

        // Response back-pressure with everybody requesting
        do_reset(2);
        keep_valid = 1'b1;
        set_req(0, SIZE'(11));
        set_req(1, SIZE'(12));
        set_req(2, SIZE'(13));
        set_req(3, SIZE'(14));
        lat = 0;
        while (lat < 40) begin
            @(negedge sys_clock);
            if (rsp_valid) break;
            tick();
            lat++;
        end
        check("t4_rsp_seen", rsp_valid, 1);
        repeat (10) begin
            tick();
            @(negedge sys_clock);
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_ready", req_ready, 4'b0000);
            check("t4_hold_q", rsp_quotient, 3);
            check("t4_hold_r", rsp_reminder, 2);
            check("t4_hold_id", rsp_id, 0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge sys_clock);
        check("t4_ready_on_hs_cycle", req_ready, 4'b0000);
        tick();
        @(negedge sys_clock);
        check("t4_idle_valid", rsp_valid, 0);
        check("t4_idle_busy", busy, 0);
        check("t4_idle_ready", req_ready, 4'b0010);
        tick();
        @(negedge sys_clock);
        check("t4_reaccept_busy", busy, 1);
        keep_valid = 1'b0;

        // Requesters 0 and 2 continuously valid
        do_reset(2);
        rsp_ready  = 1'b1;
        keep_valid = 1'b1;
        g0 = dut_grant_id.size();
        set_req(0, SIZE'(21));
        set_req(2, SIZE'(22));
        ready_seen = '0;
        wait_grants(g0 + 4, 200);
        if (dut_grant_id.size() >= g0 + 4) begin
            check("t5_grant0", dut_grant_id[g0], 0);
            check("t5_grant1", dut_grant_id[g0 + 1], 2);
            check("t5_grant2", dut_grant_id[g0 + 2], 0);
            check("t5_grant3", dut_grant_id[g0 + 3], 2);
        end
        check("t5_never_ready_1_3", ready_seen & 4'b1010, 0);
        keep_valid = 1'b0;

        // Reset during the 5th shift edge discards the job
        do_reset(2);
        rsp_ready = 1'b1;
        n0 = log_q.size();
        set_req(1, SIZE'(55));
        tick();
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge sys_clock);
        check("t6_busy_after_reset", busy, 0);
        check("t6_valid_after_reset", rsp_valid, 0);
        set_req(2, SIZE'(30));
        wait_rsps(n0 + 1, 60);
        repeat (30) tick();
        check("t6_rsp_count", log_q.size() - n0, 1);
        if (log_q.size() > n0) begin
            check("t6_q", log_q[n0], 10);
            check("t6_r", log_r[n0], 0);
            check("t6_id", log_id[n0], 2);
        end

        // Random traffic, back-pressure, drops and occasional reset
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 9))
                        0:       d = '0;
                        1:       d = '1;
                        default: d = SIZE'($urandom_range(0, (1 << SIZE) - 1));
                    endcase
                    set_req(i, d);
                end else if (req_valid[i] && $urandom_range(0, 99) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 999) == 0);
        end
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (60) tick();
        check("drain_exp_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
